// File: rtl/aq_spsram_64x58_arb_pkg.sv
// -----------------------------------------------------------------------------
// aq_spsram_64x58_arb_pkg
// Shared constants and types for the 64x58 single-port SRAM access controller.
//   ADDR_WIDTH / DATA_WIDTH : geometry of the wrapped SRAM
//   STARVE_W / STARVE_LIMIT : width and ceiling of the read-starvation counter
//   INIT_VALUE              : word swept into every entry after reset
//   arb_state_t             : controller state encoding (INIT / IDLE)
// Optional feature macro used by the controller: AQ_SPSRAM_ARB_INIT_EN
// -----------------------------------------------------------------------------
package aq_spsram_64x58_arb_pkg;

  localparam int ADDR_WIDTH = 6;
  localparam int DATA_WIDTH = 58;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  localparam int                  STARVE_W     = 3;
  localparam logic [STARVE_W-1:0] STARVE_LIMIT = 3'd4;

  localparam logic [DATA_WIDTH-1:0] INIT_VALUE = 58'b0;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/aq_spsram_64x58_arb_prio.sv
// -----------------------------------------------------------------------------
// aq_spsram_arb_prio
// Two-way priority select between the read and write requesters plus the
// read-starvation counter. Writes normally win a tie; once the counter reaches
// STARVE_LIMIT a pending read is forced through.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   grant_en   : grants allowed this cycle (initialised and not in reset)
//   rd_req     : read requester is asking
//   wr_req     : write requester is asking
//   rd_gnt     : read granted this cycle (combinational)
//   wr_gnt     : write granted this cycle (combinational)
// -----------------------------------------------------------------------------
module aq_spsram_arb_prio
  import aq_spsram_64x58_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic grant_en,
  input  logic rd_req,
  input  logic wr_req,
  output logic rd_gnt,
  output logic wr_gnt
);

  logic [STARVE_W-1:0] starve_cnt_q;
  logic [STARVE_W-1:0] starve_cnt_d;
  logic                rd_forced;

  // The counter only tracks writes that overtook a waiting read, so it is
  // cleared as soon as the read is served or stops asking.
  always_comb begin
    rd_forced    = (starve_cnt_q == STARVE_LIMIT);
    rd_gnt       = grant_en & rd_req & (~wr_req | rd_forced);
    wr_gnt       = grant_en & wr_req & ~(rd_req & rd_forced);
    starve_cnt_d = starve_cnt_q;
    if (rd_gnt || !rd_req) begin
      starve_cnt_d = '0;
    end else if (wr_gnt && !rd_forced) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/aq_spsram_64x58_arb.sv
// -----------------------------------------------------------------------------
// aq_spsram_64x58_arb
// Access controller for the 64x58 single-port SRAM wrapper. Arbitrates a
// read/lookup port and a write/refill port (per-bit mask) onto the single SRAM
// port, one access per cycle, drives the active-low CEN/GWEN/WEN encoding and
// returns read data one cycle after the read grant.
// Optional feature: define AQ_SPSRAM_ARB_INIT_EN to sweep INIT_VALUE into all
// 64 entries after reset before any grant is issued.
// Ports:
//   forever_cpuclk      : clock
//   cpurst              : synchronous active-high reset
//   rd_req/rd_addr      : read request, held until rd_gnt
//   rd_gnt              : read accepted this cycle
//   rd_vld/rd_data      : read data valid (cycle after rd_gnt) and data
//   wr_req/wr_addr/
//   wr_data/wr_mask     : write request with per-bit enable (1 = write bit)
//   wr_gnt              : write accepted this cycle
//   init_done           : array initialised, grants possible
//   sram_a/cen/gwen/
//   d/wen               : SRAM control, all enables active low
//   sram_q              : SRAM read data
// -----------------------------------------------------------------------------
module aq_spsram_64x58_arb
  import aq_spsram_64x58_arb_pkg::*;
(
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic                  wr_gnt,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_d,
  output logic [DATA_WIDTH-1:0] sram_wen,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  logic init_done_q;
  logic init_done_d;
  logic rd_vld_q;
  logic grant_en;

  // Grants are suppressed while reset is asserted so nothing reaches the SRAM
  // during reset, even though the registers only clear on the clock edge.
  assign grant_en = init_done_q & ~cpurst;

  aq_spsram_arb_prio u_prio (
    .clk      (forever_cpuclk),
    .rst      (cpurst),
    .grant_en (grant_en),
    .rd_req   (rd_req),
    .wr_req   (wr_req),
    .rd_gnt   (rd_gnt),
    .wr_gnt   (wr_gnt)
  );

`ifdef AQ_SPSRAM_ARB_INIT_EN
  arb_state_t            state_q;
  arb_state_t            state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q;
  logic [ADDR_WIDTH-1:0] init_cnt_d;
  logic                  init_active;

  // One entry per cycle during INIT; leaving after the last address means
  // init_done (registered from state_d) rises on the first IDLE cycle.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_active = (state_q == ST_INIT) & ~cpurst;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == {ADDR_WIDTH{1'b1}}) begin
        state_d = ST_IDLE;
      end
    end
    init_done_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end
`else
  // Without the sweep the array is usable one cycle after reset release.
  always_comb begin
    init_done_d = 1'b1;
  end
`endif

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      init_done_q <= 1'b0;
      rd_vld_q    <= 1'b0;
    end else begin
      init_done_q <= init_done_d;
      rd_vld_q    <= rd_gnt;
    end
  end

  // A read in flight when reset arrives is dropped, so the valid is masked
  // by reset as well as cleared by it.
  assign init_done = init_done_q;
  assign rd_vld    = rd_vld_q & ~cpurst;
  assign rd_data   = sram_q;

  // Idle encoding keeps address/data at zero to avoid needless toggling.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_a    = '0;
    sram_d    = '0;
    sram_wen  = '1;
`ifdef AQ_SPSRAM_ARB_INIT_EN
    if (init_active) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_a    = init_cnt_q;
      sram_d    = INIT_VALUE;
      sram_wen  = '0;
    end
`endif
    if (wr_gnt) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_a    = wr_addr;
      sram_d    = wr_data;
      sram_wen  = ~wr_mask;
    end else if (rd_gnt) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b1;
      sram_a    = rd_addr;
    end
  end

endmodule

// File: tb/tb_aq_spsram_64x58_arb.sv
module tb_aq_spsram_64x58_arb;
   import aq_spsram_64x58_arb_pkg::*;

   logic        forever_cpuclk = 1'b0;
   logic        cpurst = 1'b1;
   logic        rd_req = 1'b0;
   logic [5:0]  rd_addr = '0;
   logic        rd_gnt;
   logic        rd_vld;
   logic [57:0] rd_data;
   logic        wr_req = 1'b0;
   logic [5:0]  wr_addr = '0;
   logic [57:0] wr_data = '0;
   logic [57:0] wr_mask = '0;
   logic        wr_gnt;
   logic        init_done;
   logic [5:0]  sram_a;
   logic        sram_cen;
   logic        sram_gwen;
   logic [57:0] sram_d;
   logic [57:0] sram_wen;
   logic [57:0] sram_q;

   int assertCount = 0;
   int failCount = 0;
   logic [57:0] expQ[$];

   localparam logic [57:0] ALL1 = 58'h3FFFFFFFFFFFFFF;
   localparam logic [57:0] PATA = 58'h2AAAAAAAAAAAAAA;
   localparam logic [57:0] PATF = 58'h2AAAAAAAAAAAAAF;
   localparam logic [57:0] PAT5 = 58'h155555555555555;

   aq_spsram_64x58_arb dut (
      .forever_cpuclk (forever_cpuclk),
      .cpurst         (cpurst),
      .rd_req         (rd_req),
      .rd_addr        (rd_addr),
      .rd_gnt         (rd_gnt),
      .rd_vld         (rd_vld),
      .rd_data        (rd_data),
      .wr_req         (wr_req),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_mask        (wr_mask),
      .wr_gnt         (wr_gnt),
      .init_done      (init_done),
      .sram_a         (sram_a),
      .sram_cen       (sram_cen),
      .sram_gwen      (sram_gwen),
      .sram_d         (sram_d),
      .sram_wen       (sram_wen),
      .sram_q         (sram_q)
   );

   always #5 forever_cpuclk = ~forever_cpuclk;

   // Behavioural single-port SRAM with active-low bit write enables
   logic [57:0] mem [0:63];
   always @(posedge forever_cpuclk) begin
      if (sram_cen === 1'b0) begin
         if (sram_gwen === 1'b0)
            mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
         else
            sram_q <= mem[sram_a];
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rd, input logic [5:0] ra, input logic wr,
                                input logic [5:0] wa, input logic [57:0] wd, input logic [57:0] wm);
      rd_req = rd;
      rd_addr = ra;
      wr_req = wr;
      wr_addr = wa;
      wr_data = wd;
      wr_mask = wm;
   endtask

   task automatic nextCycle;
      @(posedge forever_cpuclk);
      #1;
   endtask

   task automatic issueWrite(input logic [5:0] a, input logic [57:0] d, input logic [57:0] m, input logic [57:0] expWen);
      applyStimulus(1'b0, 6'd0, 1'b1, a, d, m);
      @(negedge forever_cpuclk);
      checkOutput("wr_gnt", {63'd0, wr_gnt}, 64'd1);
      checkOutput("wr_sram_wen", {6'd0, sram_wen}, {6'd0, expWen});
      checkOutput("wr_sram_gwen", {63'd0, sram_gwen}, 64'd0);
      nextCycle();
      applyStimulus(1'b0, 6'd0, 1'b0, 6'd0, 58'd0, 58'd0);
   endtask

   task automatic issueRead(input logic [5:0] a, input logic [57:0] expData);
      applyStimulus(1'b1, a, 1'b0, 6'd0, 58'd0, 58'd0);
      @(negedge forever_cpuclk);
      checkOutput("rd_gnt", {63'd0, rd_gnt}, 64'd1);
      checkOutput("rd_sram_a", {58'd0, sram_a}, {58'd0, a});
      expQ.push_back(expData);
      nextCycle();
      applyStimulus(1'b0, 6'd0, 1'b0, 6'd0, 58'd0, 58'd0);
   endtask

   task automatic waitInitDone(input int maxCycles);
      int n = 0;
      forever begin
         @(negedge forever_cpuclk);
         if (init_done === 1'b1 || n >= maxCycles) break;
         nextCycle();
         n++;
      end
      checkOutput("init_done_rise", {63'd0, init_done}, 64'd1);
      nextCycle();
   endtask

   task automatic checkSweep(input string tag);
      for (int i = 0; i < 64; i++) begin
         @(negedge forever_cpuclk);
         checkOutput({tag, "_a"}, {58'd0, sram_a}, i);
         checkOutput({tag, "_gwen"}, {62'd0, sram_gwen, sram_cen}, 64'd0);
         checkOutput({tag, "_init_done"}, {63'd0, init_done}, 64'd0);
         nextCycle();
      end
      @(negedge forever_cpuclk);
      checkOutput({tag, "_done65"}, {63'd0, init_done}, 64'd1);
      nextCycle();
   endtask

   // Scoreboard monitor: every rd_vld consumes one expected word
   task automatic monitorLoop;
      logic [57:0] exp;
      forever begin
         @(negedge forever_cpuclk);
         if (rd_vld === 1'b1) begin
            if (expQ.size() == 0) begin
               checkOutput("rd_vld_unexpected", {63'd0, rd_vld}, 64'd0);
            end else begin
               exp = expQ.pop_front();
               checkOutput("rd_data", {6'd0, rd_data}, {6'd0, exp});
            end
         end
      end
   endtask

   // Main stimulus sequence
   initial begin
      logic expR;
      logic prevR;
      fork
         monitorLoop();
         begin
            #100000;
            $display("[TB] FAIL watchdog: got timeout expected completion");
            $fatal(1, "[TB] watchdog expired");
         end
      join_none

      // Reset with both requesters active: nothing may be granted
      nextCycle();
      nextCycle();
      applyStimulus(1'b1, 6'd3, 1'b1, 6'd4, ALL1, ALL1);
      @(negedge forever_cpuclk);
      checkOutput("rst_rd_gnt", {63'd0, rd_gnt}, 64'd0);
      checkOutput("rst_wr_gnt", {63'd0, wr_gnt}, 64'd0);
      checkOutput("rst_cen", {63'd0, sram_cen}, 64'd1);
      checkOutput("rst_gwen", {63'd0, sram_gwen}, 64'd1);
      checkOutput("rst_wen", {6'd0, sram_wen}, {6'd0, ALL1});
      checkOutput("rst_rd_vld", {63'd0, rd_vld}, 64'd0);
      checkOutput("rst_init_done", {63'd0, init_done}, 64'd0);
      nextCycle();
      applyStimulus(1'b0, 6'd0, 1'b0, 6'd0, 58'd0, 58'd0);
      cpurst = 1'b0;

`ifdef AQ_SPSRAM_ARB_INIT_EN
      checkSweep("init");
      issueRead(6'd37, INIT_VALUE);
      nextCycle();
`else
      waitInitDone(10);
`endif

      // Full-mask write then read-after-write of the same address
      issueWrite(6'd5, PATA, ALL1, 58'd0);
      issueRead(6'd5, PATA);
      nextCycle();

      // Partial-mask write: only the low nibble changes
      issueWrite(6'd5, ALL1, 58'h00000000000000F, 58'h3FFFFFFFFFFFFF0);
      issueRead(6'd5, PATF);
      nextCycle();

      // Empty mask still takes the slot and leaves data untouched
      issueWrite(6'd5, 58'd0, 58'd0, ALL1);
      issueRead(6'd5, PATF);
      nextCycle();

      // Both requesters held: W,W,W,W,R repeating
      applyStimulus(1'b1, 6'd5, 1'b1, 6'd9, PAT5, ALL1);
      prevR = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge forever_cpuclk);
         expR = ((k % 5) == 4);
         checkOutput("pat_rd_gnt", {63'd0, rd_gnt}, {63'd0, expR});
         checkOutput("pat_wr_gnt", {63'd0, wr_gnt}, {63'd0, ~expR});
         checkOutput("pat_rd_vld", {63'd0, rd_vld}, {63'd0, prevR});
         if (expR) expQ.push_back(PATF);
         prevR = expR;
         nextCycle();
      end
      applyStimulus(1'b0, 6'd0, 1'b0, 6'd0, 58'd0, 58'd0);
      nextCycle();
      issueRead(6'd9, PAT5);
      nextCycle();

      // Read granted, reset next cycle: the read is dropped
      applyStimulus(1'b1, 6'd9, 1'b0, 6'd0, 58'd0, 58'd0);
      @(negedge forever_cpuclk);
      checkOutput("drop_rd_gnt", {63'd0, rd_gnt}, 64'd1);
      nextCycle();
      cpurst = 1'b1;
      applyStimulus(1'b1, 6'd9, 1'b1, 6'd1, ALL1, ALL1);
      @(negedge forever_cpuclk);
      checkOutput("drop_rd_vld", {63'd0, rd_vld}, 64'd0);
      checkOutput("drop_cen", {63'd0, sram_cen}, 64'd1);
      checkOutput("drop_gnts", {62'd0, rd_gnt, wr_gnt}, 64'd0);
      nextCycle();
      @(negedge forever_cpuclk);
      checkOutput("drop_rd_vld2", {63'd0, rd_vld}, 64'd0);
      nextCycle();
      applyStimulus(1'b0, 6'd0, 1'b0, 6'd0, 58'd0, 58'd0);
      cpurst = 1'b0;

`ifdef AQ_SPSRAM_ARB_INIT_EN
      // Reset pulsed at sweep address 20 restarts from address 0
      for (int i = 0; i < 20; i++) nextCycle();
      @(negedge forever_cpuclk);
      checkOutput("restart_a20", {58'd0, sram_a}, 64'd20);
      nextCycle();
      cpurst = 1'b1;
      @(negedge forever_cpuclk);
      checkOutput("restart_cen", {63'd0, sram_cen}, 64'd1);
      nextCycle();
      cpurst = 1'b0;
      checkSweep("restart");
`else
      waitInitDone(10);
`endif

      // Normal operation after the second reset
      issueWrite(6'd12, PAT5, ALL1, 58'd0);
      issueRead(6'd12, PAT5);
      nextCycle();
      nextCycle();

      checkOutput("scoreboard_empty", expQ.size(), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
